// File: rtl/shared_fifo_pkg.sv
// Shared definitions for the 6-port shared FIFO drain scheduler.
package shared_fifo_pkg;

  localparam int unsigned NPORTS = 6;
  localparam int unsigned PORTW  = 3;

  typedef logic [PORTW-1:0] port_idx_t;

  localparam port_idx_t LAST_PORT = 3'd5;

  // Source of the grant issued in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_HOLD,
    GNT_ROTATE
  } grant_src_e;

  // Successor port in round-robin order, wrapping 5 -> 0.
  function automatic port_idx_t next_port(input port_idx_t idx);
    return (idx >= LAST_PORT) ? '0 : port_idx_t'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/syncfifo_shared_6_drain_arb_rr_pick6.sv
// Combinational rotating first-one picker: first requester at or after ptr, wrapping 5 -> 0.
module rr_pick6
  import shared_fifo_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  port_idx_t         ptr,
  output logic [NPORTS-1:0] gnt,
  output port_idx_t         gnt_idx,
  output logic              any
);

  port_idx_t scan;
  logic      found;

  // Walk the six ports starting at ptr; the first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    any     = |req;
    scan    = (ptr > LAST_PORT) ? '0 : ptr;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (!found && req[scan]) begin
        gnt[scan] = 1'b1;
        gnt_idx   = scan;
        found     = 1'b1;
      end
      scan = next_port(scan);
    end
  end

endmodule

// File: rtl/syncfifo_shared_6_drain_arb.sv
// Drain scheduler for the 6-port shared FIFO: weighted round-robin with a strict-priority
// class, one pop per cycle, serialised onto a single ready/valid output register.
module syncfifo_shared_6_drain_arb
  import shared_fifo_pkg::*;
#(
  parameter int WID  = 128,
  parameter int WGTW = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           softreset,
  input  logic [NPORTS-1:0]              empty,
  input  logic [NPORTS-1:0][WID-1:0]     din,
  output logic [NPORTS-1:0]              readout,
  input  logic [NPORTS-1:0]              cfg_en,
  input  logic [NPORTS-1:0]              cfg_prio,
  input  logic [NPORTS-1:0][WGTW-1:0]    cfg_wgt,
  output logic                           vldout,
  output logic [WID-1:0]                 dataout,
  output logic [PORTW-1:0]               portout,
  input  logic                           ready,
  output logic                           busy
);

  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] prio_set;
  logic [NPORTS-1:0] cand;
  logic              can_pop;

  port_idx_t         rr_ptr;
  port_idx_t         holder;
  logic              holder_vld;
  logic [WGTW-1:0]   burst_cnt;
  logic [WGTW-1:0]   quantum;
  logic              hold_ok;

  logic [NPORTS-1:0] pick_gnt;
  port_idx_t         pick_idx;
  logic              pick_any;

  grant_src_e        src;
  port_idx_t         gnt_idx;

  // Candidate set: the priority class wins whenever any of its members is eligible.
  always_comb begin
    eligible = ~empty & cfg_en;
    prio_set = eligible & cfg_prio;
    cand     = (|prio_set) ? prio_set : eligible;
    can_pop  = !vldout || ready;
  end

  // Holder may keep the grant while it is still a candidate and its quantum is not used up.
  always_comb begin
    quantum = (cfg_wgt[holder] == '0) ? WGTW'(1) : cfg_wgt[holder];
    hold_ok = holder_vld && cand[holder] && (burst_cnt < quantum);
  end

  rr_pick6 u_pick (
    .req     (cand),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Grant decision and combinational one-hot pop request to the FIFO.
  always_comb begin
    src     = GNT_NONE;
    gnt_idx = '0;
    readout = '0;
    if (rst_n && !softreset && can_pop && pick_any) begin
      if (hold_ok) begin
        src     = GNT_HOLD;
        gnt_idx = holder;
      end else begin
        src     = GNT_ROTATE;
        gnt_idx = pick_idx;
      end
      readout[gnt_idx] = 1'b1;
    end
  end

  // Arbitration state: round-robin pointer, current holder and its burst count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      holder     <= '0;
      holder_vld <= 1'b0;
      burst_cnt  <= '0;
    end else if (softreset) begin
      rr_ptr     <= '0;
      holder     <= '0;
      holder_vld <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      unique case (src)
        GNT_HOLD: begin
          burst_cnt <= burst_cnt + 1'b1;
        end
        GNT_ROTATE: begin
          holder     <= pick_idx;
          holder_vld <= 1'b1;
          burst_cnt  <= WGTW'(1);
          rr_ptr     <= next_port(pick_idx);
        end
        default: begin
        end
      endcase
    end
  end

  // One-entry output register: loads on grant, drains on accept, data/port hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldout  <= 1'b0;
      dataout <= '0;
      portout <= '0;
    end else if (softreset) begin
      vldout  <= 1'b0;
      dataout <= '0;
      portout <= '0;
    end else if (src != GNT_NONE) begin
      vldout  <= 1'b1;
      dataout <= din[gnt_idx];
      portout <= gnt_idx;
    end else if (ready) begin
      vldout  <= 1'b0;
    end
  end

  // Busy while a word is held or any port still has drainable data.
  always_comb begin
    busy = vldout || (|eligible);
  end

endmodule

// File: tb/tb_syncfifo_shared_6_drain_arb.sv
// Self-checking bench for the drain scheduler: per-port FIFO queues feed the DUT and a
// queue-based reference model predicts every pop and every output word.
module tb_syncfifo_shared_6_drain_arb;
  import shared_fifo_pkg::*;

  localparam int WID  = 128;
  localparam int WGTW = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        softreset;
  logic [5:0]                  empty;
  logic [5:0][WID-1:0]         din;
  logic [5:0]                  readout;
  logic [5:0]                  cfg_en;
  logic [5:0]                  cfg_prio;
  logic [5:0][WGTW-1:0]        cfg_wgt;
  logic                        vldout;
  logic [WID-1:0]              dataout;
  logic [2:0]                  portout;
  logic                        ready;
  logic                        busy;

  syncfifo_shared_6_drain_arb #(.WID(WID), .WGTW(WGTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .softreset (softreset),
    .empty     (empty),
    .din       (din),
    .readout   (readout),
    .cfg_en    (cfg_en),
    .cfg_prio  (cfg_prio),
    .cfg_wgt   (cfg_wgt),
    .vldout    (vldout),
    .dataout   (dataout),
    .portout   (portout),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO contents seen by the DUT, and the model's view of the scheduler.
  logic [WID-1:0] q [6][$];
  int             m_rr;
  int             m_hold;
  int             m_cnt;
  bit             m_vld;
  logic [WID-1:0] m_data;
  int             m_port;
  int             gseq [$];
  int             seqno = 0;
  int             checks = 0;
  int             failures = 0;

  typedef struct {
    logic [5:0] empty;
    logic [5:0] en;
    logic [5:0] prio;
    logic [5:0] rd;
    logic       busy;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_rr   = 0;
    m_hold = -1;
    m_cnt  = 0;
    m_vld  = 1'b0;
    m_data = '0;
    m_port = 0;
  endfunction

  function automatic logic [WID-1:0] mkword(input int p);
    seqno++;
    return {32'(p), 32'(seqno), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [5:0] elig_set();
    logic [5:0] e;
    for (int i = 0; i < 6; i++) e[i] = (q[i].size() != 0) && cfg_en[i];
    return e;
  endfunction

  // Which port the scheduler should pop this cycle (-1 = none); cont = holder continues.
  function automatic int model_grant(output bit cont);
    logic [5:0] e;
    logic [5:0] c;
    int         w;
    cont = 1'b0;
    e = elig_set();
    c = ((e & cfg_prio) != 0) ? (e & cfg_prio) : e;
    if (!rst_n || softreset || (m_vld && !ready) || c == 0) return -1;
    if (m_hold >= 0) begin
      w = int'(cfg_wgt[m_hold]);
      if (w == 0) w = 1;
      if (c[m_hold] && m_cnt < w) begin
        cont = 1'b1;
        return m_hold;
      end
    end
    for (int k = 0; k < 6; k++) begin
      int p;
      p = (m_rr + k) % 6;
      if (c[p]) return p;
    end
    return -1;
  endfunction

  task automatic drive_fifo();
    for (int i = 0; i < 6; i++) begin
      empty[i] = (q[i].size() == 0);
      din[i]   = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  // One cycle: drive FIFO view, check all outputs against the model, clock, update model.
  task automatic step();
    int         g;
    bit         cont;
    logic [5:0] exp_rd;
    drive_fifo();
    #1;
    g = model_grant(cont);
    exp_rd = (g >= 0) ? 6'(1 << g) : 6'b0;
    chk("readout", readout, exp_rd);
    chk("pop_empty", readout & empty, '0);
    chk("vldout", vldout, m_vld);
    chk("dataout", dataout, m_data);
    chk("portout", portout, m_port);
    chk("busy", busy, m_vld || (elig_set() != 0));
    for (int i = 0; i < 6; i++) if (readout[i]) gseq.push_back(i);
    @(posedge clk);
    if (softreset) begin
      model_reset();
    end else if (g >= 0) begin
      m_data = q[g].pop_front();
      m_port = g;
      m_vld  = 1'b1;
      if (cont) begin
        m_cnt++;
      end else begin
        m_hold = g;
        m_cnt  = 1;
        m_rr   = (g + 1) % 6;
      end
    end else if (m_vld && ready) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic sreset();
    softreset = 1'b1;
    step();
    softreset = 1'b0;
    for (int i = 0; i < 6; i++) q[i].delete();
    gseq.delete();
  endtask

  task automatic load_all(input int n);
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < n; k++) q[i].push_back(mkword(i));
  endtask

  task automatic chk_seq(input string name, input int e [$]);
    for (int k = 0; k < e.size(); k++)
      chk(name, (k < gseq.size()) ? WID'(gseq[k]) : '1, WID'(e[k]));
  endtask

  initial begin
    int             e [$];
    logic [WID-1:0] held;

    rst_n     = 1'b0;
    softreset = 1'b0;
    ready     = 1'b1;
    cfg_en    = '1;
    cfg_prio  = '0;
    for (int i = 0; i < 6; i++) cfg_wgt[i] = 4'd1;
    model_reset();

    // Reset: pops held off while rst_n is low, port 0 first after release.
    load_all(3);
    drive_fifo();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_readout", readout, '0);
    chk("reset_vldout", vldout, '0);
    chk("reset_dataout", dataout, '0);
    chk("reset_portout", portout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_fifo();
    #1;
    chk("release_pop", readout, 6'b000001);
    repeat (3) step();

    // Table: first grant from a cleared state for assorted eligibility patterns.
    tbl[0] = '{6'b111111, 6'b111111, 6'b000000, 6'b000000, 1'b0};
    tbl[1] = '{6'b000000, 6'b111111, 6'b000000, 6'b000001, 1'b1};
    tbl[2] = '{6'b000011, 6'b111111, 6'b000000, 6'b000100, 1'b1};
    tbl[3] = '{6'b000000, 6'b111110, 6'b000000, 6'b000010, 1'b1};
    tbl[4] = '{6'b000000, 6'b111111, 6'b010000, 6'b010000, 1'b1};
    tbl[5] = '{6'b010000, 6'b111111, 6'b010000, 6'b000001, 1'b1};
    tbl[6] = '{6'b000000, 6'b000000, 6'b111111, 6'b000000, 1'b0};
    tbl[7] = '{6'b000000, 6'b100000, 6'b000000, 6'b100000, 1'b1};
    tbl[8] = '{6'b001000, 6'b111111, 6'b101000, 6'b100000, 1'b1};
    for (int t = 0; t < 9; t++) begin
      softreset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      softreset = 1'b0;
      ready     = 1'b1;
      empty     = tbl[t].empty;
      cfg_en    = tbl[t].en;
      cfg_prio  = tbl[t].prio;
      #1;
      chk($sformatf("tbl%0d_readout", t), readout, tbl[t].rd);
      chk($sformatf("tbl%0d_busy", t), busy, tbl[t].busy);
      softreset = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    softreset = 1'b0;
    cfg_en    = '1;
    cfg_prio  = '0;
    model_reset();
    for (int i = 0; i < 6; i++) q[i].delete();

    // Plain round robin, quantum 1.
    sreset();
    load_all(3);
    repeat (20) step();
    e = '{0,1,2,3,4,5,0,1,2,3,4,5,0,1,2,3,4,5};
    chk_seq("rr_seq", e);

    // Port 2 bursts three words per turn.
    sreset();
    cfg_wgt[2] = 4'd3;
    load_all(3);
    repeat (20) step();
    e = '{0,1,2,2,2,3,4,5,0,1,3,4,5};
    chk_seq("wgt_seq", e);
    cfg_wgt[2] = 4'd1;

    // Port 4 in the priority class drains first, then round robin resumes after it.
    sreset();
    cfg_prio = 6'b010000;
    load_all(3);
    repeat (20) step();
    e = '{4,4,4,5,0,1,2,3,5,0,1,2,3};
    chk_seq("prio_seq", e);
    cfg_prio = '0;

    // Backpressure: no pops and stable data while ready is low; pop resumes with ready.
    sreset();
    load_all(3);
    step();
    held  = dataout;
    ready = 1'b0;
    repeat (5) begin
      step();
      chk("bp_readout", readout, '0);
      chk("bp_data_hold", dataout, held);
    end
    ready = 1'b1;
    drive_fifo();
    #1;
    chk("bp_resume_pop", readout, 6'b000010);
    step();

    // Softreset with a word stuck in the output register.
    sreset();
    load_all(3);
    repeat (3) step();
    ready     = 1'b0;
    softreset = 1'b1;
    drive_fifo();
    #1;
    chk("srst_no_pop", readout, '0);
    step();
    softreset = 1'b0;
    chk("srst_vld_drop", vldout, '0);
    ready = 1'b1;
    drive_fifo();
    #1;
    chk("srst_ptr_zero", readout, 6'b000001);
    step();

    // Randomised traffic, configuration churn and occasional softreset.
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) begin
        cfg_en   = ($urandom_range(3) == 0) ? 6'($urandom) : 6'b111111;
        cfg_prio = ($urandom_range(2) == 0) ? (6'($urandom) & 6'($urandom)) : 6'b000000;
        for (int i = 0; i < 6; i++) cfg_wgt[i] = 4'($urandom_range(4));
      end
      softreset = ($urandom_range(199) == 0);
      if ($urandom_range(1) != 0) begin
        int p;
        p = int'($urandom_range(5));
        if (q[p].size() < 8) q[p].push_back(mkword(p));
      end
      step();
    end
    softreset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
